axi_lite_reg_slave: RTL and testbench
=====================================

// Module: axi_lite_reg_slave
// PURPOSE
//  AXI4-Lite register-bank slave that sits directly downstream of the bus
//  interconnect and attaches to one of its master ports (m1 or m2).
//  Holds NUM_REGS word registers with byte-strobe writes and returns OKAY or
//  SLVERR responses. Write and read channels run as independent state machines.
// PARAMETERS
//  DATA_WIDTH  32  data width in bits; a multiple of 8
//  ADDR_WIDTH  8   byte-address width
//  RESP_WIDTH  3   response width, matching the bus; OKAY=0, SLVERR=2
//  NUM_REGS    4   number of word registers; byte window = NUM_REGS*DATA_WIDTH/8
//  BASE_ADDR   0   byte address of register 0
// PORTS
//  s_axi_aclk     in   1               single clock; all logic on the rising edge
//  s_axi_areset   in   1               synchronous reset, active-high
//  s_axi_awaddr   in   ADDR_WIDTH      write address
//  s_axi_awvalid  in   1               write address valid
//  s_axi_awready  out  1               write address ready
//  s_axi_wdata    in   DATA_WIDTH      write data
//  s_axi_wstrb    in   DATA_WIDTH/8+1  byte strobes; bit [DATA_WIDTH/8] ignored
//  s_axi_wvalid   in   1               write data valid
//  s_axi_wready   out  1               write data ready
//  s_axi_bresp    out  RESP_WIDTH      write response
//  s_axi_bvalid   out  1               write response valid
//  s_axi_bready   in   1               write response ready
//  s_axi_araddr   in   ADDR_WIDTH      read address
//  s_axi_arvalid  in   1               read address valid
//  s_axi_arready  out  1               read address ready
//  s_axi_rdata    out  DATA_WIDTH      read data
//  s_axi_rresp    out  RESP_WIDTH      read response
//  s_axi_rvalid   out  1               read data valid
//  s_axi_rready   in   1               read data ready
// BEHAVIOUR
//  - Reset: regs=0, both FSMs go to IDLE, bvalid=rvalid=0, bresp=rresp=0,
//    rdata=0. The ready outputs are decoded from state, so
//    awready=wready=arready=1 while reset is asserted and on the cycle after.
//    Reset mid-transaction discards any captured address/data and any pending
//    response without committing.
//  - Decode: idx = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); addr[1:0] ignored.
//    addr < BASE_ADDR or idx >= NUM_REGS marks the access out-of-range.
//  - Write FSM states: W_IDLE (awready=1, wready=1), W_NEED_D (wready=1),
//    W_NEED_A (awready=1), W_RESP (bvalid=1, readies=0).
//    W_IDLE: AW+W on the same edge -> commit -> W_RESP; AW only -> latch
//    address -> W_NEED_D; W only -> latch data/strb -> W_NEED_A.
//    W_NEED_D/W_NEED_A: the missing handshake -> commit -> W_RESP.
//    W_RESP: bvalid && bready -> W_IDLE. bresp is held stable while bvalid=1.
//  - Commit: for each byte b, if strb[b]=1 then reg[idx][8b+7:8b] <= wdata byte.
//    In range: bresp=OKAY. Out of range: no register changes, bresp=SLVERR.
//    strb=0 in range: no change, bresp=OKAY.
//  - Write latency: bvalid rises on the edge after the last of AW/W completes.
//  - Read FSM states: R_IDLE (arready=1), R_DATA (rvalid=1).
//    ar handshake -> capture rdata/rresp -> R_DATA; rvalid && rready -> R_IDLE.
//    Out of range: rdata=0, rresp=SLVERR. rdata/rresp held while rvalid=1.
//  - Read latency: rvalid rises on the edge after the ar handshake. Back-to-back
//    throughput is 1 read per 2 cycles; arready=0 while in R_DATA.
//  - Simultaneous commit and ar capture to the same register on one edge:
//    the read returns the pre-write value.
//  - A stalled bready does not block reads, and a stalled rready does not
//    block writes.
// TESTING
//  1 reset -> awready=wready=arready=1, bvalid=rvalid=0; read 0x00 -> rdata=0, OKAY
//  2 AW+W same cycle: addr 0x04, data 0x38, strb 0xF -> bvalid next cycle with
//    OKAY; read 0x04 -> 0x00000038
//  3 W first (0xAABBCCDD, strb 0x5), AW 3 cycles later at 0x08 -> reg2 = 0x00BB00DD;
//    bvalid is held 4 cycles under bready=0 with bresp stable
//  4 write to 0x10 (out of range, NUM_REGS=4) -> SLVERR, regs unchanged;
//    read 0x10 -> rdata=0, rresp=SLVERR
//  5 rready held low 5 cycles -> rvalid/rdata stable, arready=0; a concurrent
//    write to 0x0C still completes with OKAY
//  6 reset asserted in W_NEED_D -> no commit, bvalid=0, FSM in W_IDLE next cycle

Source files
------------

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave
//   AXI4-Lite register-bank slave. Holds NUM_REGS word registers written with
//   byte strobes and read back one word per transaction. The write and read
//   channels are independent state machines, so a stalled response on one
//   channel never blocks the other.
//
// Ports
//   s_axi_aclk     in   clock, all logic on the rising edge
//   s_axi_areset   in   synchronous reset, active-high
//   s_axi_aw*      write address channel (awaddr, awvalid in; awready out)
//   s_axi_w*       write data channel (wdata, wstrb, wvalid in; wready out)
//                  wstrb carries one spare top bit that is ignored
//   s_axi_b*       write response channel (bresp, bvalid out; bready in)
//   s_axi_ar*      read address channel (araddr, arvalid in; arready out)
//   s_axi_r*       read data channel (rdata, rresp, rvalid out; rready in)
module axi_lite_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int NUM_REGS   = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] NREGS       = ADDR_WIDTH'(NUM_REGS);

  typedef enum logic [1:0] {W_IDLE, W_NEED_D, W_NEED_A, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [BYTES-1:0]      wr_strb_q;

  logic                  commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [BYTES-1:0]      c_strb;

  logic aw_hs, w_hs, ar_hs;
  logic unused_wstrb_msb;

  logic [ADDR_WIDTH-1:0] c_word, ar_word;
  logic                  c_in_range, ar_in_range;
  logic [IDX_W-1:0]      c_idx, ar_idx;

  // Word index relative to the base; the sub-word byte bits drop out in the
  // shift. Subtraction wraps for addresses below the base, which is why the
  // range check also compares against BASE directly.
  function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE;
    return off >> ADDR_LSB;
  endfunction

  assign unused_wstrb_msb = s_axi_wstrb[BYTES];

  // Ready/valid outputs are pure state decodes.
  assign s_axi_awready = (w_state == W_IDLE) || (w_state == W_NEED_A);
  assign s_axi_wready  = (w_state == W_IDLE) || (w_state == W_NEED_D);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_arready = (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_DATA);

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  assign c_word      = word_index(c_addr);
  assign c_in_range  = (c_addr >= BASE) && (c_word < NREGS);
  assign c_idx       = c_word[IDX_W-1:0];
  assign ar_word     = word_index(s_axi_araddr);
  assign ar_in_range = (s_axi_araddr >= BASE) && (ar_word < NREGS);
  assign ar_idx      = ar_word[IDX_W-1:0];

  // Write next-state. The commit source mixes live bus inputs with whatever
  // half of the transaction was latched earlier, depending on arrival order.
  always_comb begin
    w_next = w_state;
    commit = 1'b0;
    c_addr = wr_addr_q;
    c_data = wr_data_q;
    c_strb = wr_strb_q;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          c_addr = s_axi_awaddr;
          c_data = s_axi_wdata;
          c_strb = s_axi_wstrb[BYTES-1:0];
          w_next = W_RESP;
        end else if (aw_hs) begin
          w_next = W_NEED_D;
        end else if (w_hs) begin
          w_next = W_NEED_A;
        end
      end
      W_NEED_D: begin
        if (w_hs) begin
          commit = 1'b1;
          c_data = s_axi_wdata;
          c_strb = s_axi_wstrb[BYTES-1:0];
          w_next = W_RESP;
        end
      end
      W_NEED_A: begin
        if (aw_hs) begin
          commit = 1'b1;
          c_addr = s_axi_awaddr;
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write state, half-transaction latches, response and the register bank.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state     <= W_IDLE;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
      s_axi_bresp <= RESP_OKAY;
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && aw_hs) wr_addr_q <= s_axi_awaddr;
      if (w_state == W_IDLE && w_hs) begin
        wr_data_q <= s_axi_wdata;
        wr_strb_q <= s_axi_wstrb[BYTES-1:0];
      end
      if (commit) begin
        s_axi_bresp <= c_in_range ? RESP_OKAY : RESP_SLVERR;
        if (c_in_range) begin
          for (int b = 0; b < BYTES; b++) begin
            if (c_strb[b]) regs[c_idx][8*b +: 8] <= c_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read next-state.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (s_axi_arvalid) r_next = R_DATA;
      R_DATA:  if (s_axi_rready)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read state and captured data. Capturing from regs with a non-blocking
  // read means a write committing on the same edge is not yet visible, so
  // the read returns the pre-write value.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state     <= R_IDLE;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        s_axi_rdata <= ar_in_range ? regs[ar_idx] : '0;
        s_axi_rresp <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave
//   Directed bench for axi_lite_reg_slave with a transaction-level register
//   model. Expected responses are queued when a transaction is issued and a
//   single compare process checks every valid response beat against them.
module tb_axi_lite_reg_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [4:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [2:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_regs [4];
  logic [2:0]  exp_bresp_q [$];
  logic [31:0] exp_rdata_q [$];
  logic [2:0]  exp_rresp_q [$];

  always #5 clk = ~clk;

  axi_lite_reg_slave dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (reset),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Register model: 16-byte window of four words, low address bits ignored,
  // top strobe bit ignored.
  function automatic logic [2:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                             input logic [4:0] strb);
    if (addr >= 8'h10) return 3'd2;
    for (int b = 0; b < 4; b++)
      if (strb[b]) model_regs[addr >> 2][8*b +: 8] = data[8*b +: 8];
    return 3'd0;
  endfunction

  task automatic model_read(input logic [7:0] addr, output logic [31:0] data, output logic [2:0] resp);
    if (addr >= 8'h10) begin
      data = 32'h0;
      resp = 3'd2;
    end else begin
      data = model_regs[addr >> 2];
      resp = 3'd0;
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 4; r++) model_regs[r] = 32'h0;
    exp_bresp_q.delete();
    exp_rdata_q.delete();
    exp_rresp_q.delete();
  endtask

  // Single compare process: every response beat must match the head of its
  // queue; a beat with nothing expected is an error. Handshakes seen here
  // complete on the following rising edge, so the head is retired now.
  always @(negedge clk) begin
    if (!reset) begin
      if (bvalid) begin
        if (exp_bresp_q.size() == 0) checkOutput("bvalid_unexpected", {31'b0, bvalid}, 32'h0);
        else begin
          checkOutput("bresp_model", {29'b0, bresp}, {29'b0, exp_bresp_q[0]});
          if (bready) void'(exp_bresp_q.pop_front());
        end
      end
      if (rvalid) begin
        if (exp_rdata_q.size() == 0) checkOutput("rvalid_unexpected", {31'b0, rvalid}, 32'h0);
        else begin
          checkOutput("rdata_model", rdata, exp_rdata_q[0]);
          checkOutput("rresp_model", {29'b0, rresp}, {29'b0, exp_rresp_q[0]});
          if (rready) begin
            void'(exp_rdata_q.pop_front());
            void'(exp_rresp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic aw_v, input logic [7:0] aw_a, input logic w_v,
                               input logic [31:0] w_d, input logic [4:0] w_s);
    awvalid = aw_v;
    awaddr  = aw_a;
    wvalid  = w_v;
    wdata   = w_d;
    wstrb   = w_s;
  endtask

  task automatic do_read(input logic [7:0] addr, input int stall,
                         output logic [31:0] data, output logic [2:0] resp);
    logic [31:0] md;
    logic [2:0]  mr;
    checkOutput("arready_idle", {31'b0, arready}, 32'h1);
    model_read(addr, md, mr);
    exp_rdata_q.push_back(md);
    exp_rresp_q.push_back(mr);
    araddr  = addr;
    arvalid = 1'b1;
    wait_cycle();
    arvalid = 1'b0;
    checkOutput("rvalid_latency", {31'b0, rvalid}, 32'h1);
    for (int i = 0; i < stall; i++) begin
      checkOutput("arready_busy", {31'b0, arready}, 32'h0);
      wait_cycle();
      checkOutput("rvalid_held", {31'b0, rvalid}, 32'h1);
    end
    data   = rdata;
    resp   = rresp;
    rready = 1'b1;
    wait_cycle();
    rready = 1'b0;
    checkOutput("rvalid_drop", {31'b0, rvalid}, 32'h0);
  endtask

  // lead = 0: AW and W together; lead > 0: W first, AW lead cycles later;
  // lead < 0: AW first, W -lead cycles later.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                          input int lead, input int stall, output logic [2:0] resp);
    if (lead == 0) begin
      applyStimulus(1'b1, addr, 1'b1, data, strb);
      wait_cycle();
      applyStimulus(1'b0, 8'h0, 1'b0, 32'h0, 5'h0);
    end else if (lead > 0) begin
      applyStimulus(1'b0, 8'h0, 1'b1, data, strb);
      wait_cycle();
      applyStimulus(1'b0, 8'h0, 1'b0, 32'h0, 5'h0);
      checkOutput("need_a_wready", {31'b0, wready}, 32'h0);
      checkOutput("need_a_awready", {31'b0, awready}, 32'h1);
      for (int i = 1; i < lead; i++) begin
        wait_cycle();
        checkOutput("need_a_bvalid", {31'b0, bvalid}, 32'h0);
      end
      applyStimulus(1'b1, addr, 1'b0, 32'h0, 5'h0);
      wait_cycle();
      applyStimulus(1'b0, 8'h0, 1'b0, 32'h0, 5'h0);
    end else begin
      applyStimulus(1'b1, addr, 1'b0, 32'h0, 5'h0);
      wait_cycle();
      applyStimulus(1'b0, 8'h0, 1'b0, 32'h0, 5'h0);
      checkOutput("need_d_awready", {31'b0, awready}, 32'h0);
      checkOutput("need_d_wready", {31'b0, wready}, 32'h1);
      for (int i = 1; i < -lead; i++) begin
        wait_cycle();
        checkOutput("need_d_bvalid", {31'b0, bvalid}, 32'h0);
      end
      applyStimulus(1'b0, 8'h0, 1'b1, data, strb);
      wait_cycle();
      applyStimulus(1'b0, 8'h0, 1'b0, 32'h0, 5'h0);
    end
    exp_bresp_q.push_back(model_write(addr, data, strb));
    checkOutput("bvalid_latency", {31'b0, bvalid}, 32'h1);
    checkOutput("awready_in_resp", {31'b0, awready}, 32'h0);
    for (int i = 0; i < stall; i++) begin
      wait_cycle();
      checkOutput("bvalid_held", {31'b0, bvalid}, 32'h1);
    end
    resp   = bresp;
    bready = 1'b1;
    wait_cycle();
    bready = 1'b0;
    checkOutput("bvalid_drop", {31'b0, bvalid}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d, d2;
    logic [2:0]  r, r2, br, br2;

    reset = 1'b1;
    applyStimulus(1'b0, 8'h0, 1'b0, 32'h0, 5'h0);
    arvalid = 1'b0; araddr = 8'h0; bready = 1'b0; rready = 1'b0;
    model_reset();

    // Reset state, during and on the cycle after reset.
    wait_cycle();
    checkOutput("rst_awready", {31'b0, awready}, 32'h1);
    checkOutput("rst_wready", {31'b0, wready}, 32'h1);
    checkOutput("rst_arready", {31'b0, arready}, 32'h1);
    checkOutput("rst_bvalid", {31'b0, bvalid}, 32'h0);
    checkOutput("rst_rvalid", {31'b0, rvalid}, 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_bresp", {29'b0, bresp}, 32'h0);
    checkOutput("rst_rresp", {29'b0, rresp}, 32'h0);
    wait_cycle();
    reset = 1'b0;
    wait_cycle();
    checkOutput("post_rst_awready", {31'b0, awready}, 32'h1);
    checkOutput("post_rst_arready", {31'b0, arready}, 32'h1);

    $display("[TB] reset read");
    do_read(8'h00, 0, d, r);
    checkOutput("t1_rdata_lit", d, 32'h0);
    checkOutput("t1_rresp_lit", {29'b0, r}, 32'h0);

    $display("[TB] aligned write");
    do_write(8'h04, 32'h38, 5'h0F, 0, 0, br);
    checkOutput("t2_bresp_lit", {29'b0, br}, 32'h0);
    do_read(8'h04, 0, d, r);
    checkOutput("t2_rdata_lit", d, 32'h00000038);

    $display("[TB] data-first write with stalled bready");
    do_write(8'h08, 32'hAABBCCDD, 5'h05, 3, 4, br);
    checkOutput("t3_bresp_lit", {29'b0, br}, 32'h0);
    do_read(8'h08, 0, d, r);
    checkOutput("t3_rdata_lit", d, 32'h00BB00DD);

    $display("[TB] out-of-range and boundary accesses");
    do_write(8'h10, 32'hFFFFFFFF, 5'h1F, 0, 0, br);
    checkOutput("t4_bresp_lit", {29'b0, br}, 32'h2);
    for (int a = 0; a < 16; a += 4) do_read(8'(a), 0, d, r);
    do_read(8'h10, 0, d, r);
    checkOutput("t4_rdata_lit", d, 32'h0);
    checkOutput("t4_rresp_lit", {29'b0, r}, 32'h2);
    do_write(8'h0F, 32'h11223344, 5'h0F, -2, 0, br);
    do_read(8'h0C, 0, d, r);
    checkOutput("t4_top_word_lit", d, 32'h11223344);
    do_write(8'h04, 32'hFFFFFFFF, 5'h10, 0, 0, br);
    checkOutput("t4_nostrb_bresp_lit", {29'b0, br}, 32'h0);
    do_read(8'h04, 0, d, r);
    checkOutput("t4_nostrb_rdata_lit", d, 32'h00000038);

    $display("[TB] stalled rready with concurrent write");
    fork
      do_read(8'h08, 5, d, r);
      do_write(8'h0C, 32'hCAFEF00D, 5'h0F, 0, 0, br);
    join
    checkOutput("t5_rdata_lit", d, 32'h00BB00DD);
    checkOutput("t5_bresp_lit", {29'b0, br}, 32'h0);
    do_read(8'h0C, 0, d, r);
    checkOutput("t5_wr_lit", d, 32'hCAFEF00D);

    $display("[TB] stalled bready with concurrent read");
    fork
      do_write(8'h00, 32'h12345678, 5'h0F, 0, 4, br);
      begin
        wait_cycle();
        do_read(8'h0C, 0, d2, r2);
      end
    join
    checkOutput("t5b_rdata_lit", d2, 32'hCAFEF00D);

    $display("[TB] write and read of one register on the same edge");
    model_read(8'h04, d, r);
    exp_rdata_q.push_back(d);
    exp_rresp_q.push_back(r);
    applyStimulus(1'b1, 8'h04, 1'b1, 32'h00000099, 5'h0F);
    araddr = 8'h04; arvalid = 1'b1;
    wait_cycle();
    applyStimulus(1'b0, 8'h0, 1'b0, 32'h0, 5'h0);
    arvalid = 1'b0;
    exp_bresp_q.push_back(model_write(8'h04, 32'h00000099, 5'h0F));
    checkOutput("same_edge_pre_lit", rdata, 32'h00000038);
    bready = 1'b1; rready = 1'b1;
    wait_cycle();
    bready = 1'b0; rready = 1'b0;
    do_read(8'h04, 0, d, r);
    checkOutput("same_edge_post_lit", d, 32'h00000099);

    $display("[TB] reset while waiting for write data");
    applyStimulus(1'b1, 8'h00, 1'b0, 32'h0, 5'h0);
    wait_cycle();
    applyStimulus(1'b0, 8'h0, 1'b0, 32'h0, 5'h0);
    checkOutput("t6_need_d_awready", {31'b0, awready}, 32'h0);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h0, 1'b1, 32'h0000DEAD, 5'h0F);
    wait_cycle();
    reset = 1'b0;
    applyStimulus(1'b0, 8'h0, 1'b0, 32'h0, 5'h0);
    model_reset();
    checkOutput("t6_bvalid", {31'b0, bvalid}, 32'h0);
    checkOutput("t6_awready", {31'b0, awready}, 32'h1);
    checkOutput("t6_wready", {31'b0, wready}, 32'h1);
    wait_cycle();
    checkOutput("t6_bvalid_later", {31'b0, bvalid}, 32'h0);
    do_write(8'h04, 32'h5A5A5A5A, 5'h0F, 2, 0, br);
    do_read(8'h00, 0, d, r);
    checkOutput("t6_reg0_lit", d, 32'h0);
    do_read(8'h04, 0, d, r);
    checkOutput("t6_reg1_lit", d, 32'h5A5A5A5A);

    wait_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
